// File: rtl/sprite_blit_source.sv
// Write-side client of the double-buffered frame manager: copies a sprite from a
// sync-read ROM into the back buffer, one pixel per clock, clipping off-screen pixels.
module sprite_blit_source #(
    parameter int SOURCE_ID        = 0,
    parameter int SOURCE_SEL_ADDRW = 1,
    parameter int DRAW_WIDTH       = 640,
    parameter int DRAW_HEIGHT      = 480,
    parameter int SPRITE_W         = 32,
    parameter int SPRITE_H         = 32,
    parameter int COLOR_DEPTH      = 9,
    parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_COLOR = 9'h1FF,
    localparam int XW = $clog2(DRAW_WIDTH),
    localparam int YW = $clog2(DRAW_HEIGHT),
    localparam int AW = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write_awaited,
    input  logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    input  logic [XW-1:0]               sprite_x,
    input  logic [YW-1:0]               sprite_y,
    input  logic                        sprite_visible,
    output logic [AW-1:0]               rom_addr,
    input  logic [COLOR_DEPTH-1:0]      rom_data,
    output logic                        write_active,
    output logic [XW-1:0]               write_x_addr,
    output logic [YW-1:0]               write_y_addr,
    output logic [COLOR_DEPTH-1:0]      write_color_data,
    output logic                        write_transparent,
    output logic                        draw_done,
    output logic [2:0]                  state_dbg
);

    localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAW    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_STUB    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    // Handshake: the manager raises write_awaited with our index on write_source_sel;
    // we answer with one contiguous write_active burst and its fall hands the grant back.
    // RELEASE waits for the lagging grant to drop so it cannot start a second pass.
    logic grant;
    assign grant = write_awaited && (write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));

    logic [2:0]    state_q, state_d;
    logic [XW-1:0] lx_q, lx_d;
    logic [YW-1:0] ly_q, ly_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Stage 1: ROM address plus the wide screen coordinate of that pixel.
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_stub_q, s1_stub_d;
    logic [XW:0]   s1_x_q, s1_x_d;
    logic [YW:0]   s1_y_q, s1_y_d;

    // Stage 2: aligned with rom_data.
    logic          write_active_q, write_active_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [YW-1:0] wy_q, wy_d;
    logic          clip_q, clip_d;
    logic          draw_done_q, draw_done_d;

    always_comb begin
        state_d    = state_q;
        lx_d       = lx_q;
        ly_d       = ly_q;
        col_d      = col_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        s1_valid_d = 1'b0;
        s1_stub_d  = 1'b0;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    lx_d    = sprite_x;
                    ly_d    = sprite_y;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = sprite_visible ? S_DRAW : S_STUB;
                end
            end
            S_DRAW: begin
                rom_addr_d = AW'(int'(row_q) * SPRITE_W + int'(col_q));
                s1_valid_d = 1'b1;
                s1_x_d     = {1'b0, lx_q} + (XW+1)'(col_q);
                s1_y_d     = {1'b0, ly_q} + (YW+1)'(row_q);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_RELEASE;
            end
            S_STUB: begin
                // Invisible sprite still needs one write_active pulse for the manager.
                rom_addr_d = '0;
                s1_valid_d = 1'b1;
                s1_stub_d  = 1'b1;
                s1_x_d     = '0;
                s1_y_d     = '0;
                state_d    = S_RELEASE;
            end
            S_RELEASE: begin
                if (!grant) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        write_active_d = s1_valid_q;
        wx_d           = s1_valid_q ? s1_x_q[XW-1:0] : '0;
        wy_d           = s1_valid_q ? s1_y_q[YW-1:0] : '0;
        clip_d         = s1_valid_q && (s1_stub_q
                                        || (s1_x_q >= (XW+1)'(DRAW_WIDTH))
                                        || (s1_y_q >= (YW+1)'(DRAW_HEIGHT)));
        draw_done_d    = write_active_q && !s1_valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            lx_q           <= '0;
            ly_q           <= '0;
            col_q          <= '0;
            row_q          <= '0;
            rom_addr_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_stub_q      <= 1'b0;
            s1_x_q         <= '0;
            s1_y_q         <= '0;
            write_active_q <= 1'b0;
            wx_q           <= '0;
            wy_q           <= '0;
            clip_q         <= 1'b0;
            draw_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lx_q           <= lx_d;
            ly_q           <= ly_d;
            col_q          <= col_d;
            row_q          <= row_d;
            rom_addr_q     <= rom_addr_d;
            s1_valid_q     <= s1_valid_d;
            s1_stub_q      <= s1_stub_d;
            s1_x_q         <= s1_x_d;
            s1_y_q         <= s1_y_d;
            write_active_q <= write_active_d;
            wx_q           <= wx_d;
            wy_q           <= wy_d;
            clip_q         <= clip_d;
            draw_done_q    <= draw_done_d;
        end
    end

    assign rom_addr          = rom_addr_q;
    assign write_active      = write_active_q;
    assign write_x_addr      = wx_q;
    assign write_y_addr      = wy_q;
    assign write_color_data  = rom_data;
    assign write_transparent = write_active_q && (clip_q || (rom_data == TRANSPARENT_COLOR));
    assign draw_done         = draw_done_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_sprite_blit_source.sv
// Bench for sprite_blit_source: random passes scored against a pixel-list model
// built from sprite position, ROM contents and the screen bounds.
module tb_sprite_blit_source;

    localparam int DW   = 640;
    localparam int DH   = 480;
    localparam int SW   = 4;
    localparam int SH   = 2;
    localparam int NPIX = SW * SH;
    localparam int SRC  = 1;
    localparam logic [8:0] TC = 9'h1FF;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       write_awaited = 1'b0;
    logic [1:0] write_source_sel = 2'd0;
    logic [9:0] sprite_x = '0;
    logic [8:0] sprite_y = '0;
    logic       sprite_visible = 1'b0;
    logic [2:0] rom_addr;
    logic [8:0] rom_data = '0;
    logic       write_active;
    logic [9:0] write_x_addr;
    logic [8:0] write_y_addr;
    logic [8:0] write_color_data;
    logic       write_transparent;
    logic       draw_done;
    logic [2:0] state_dbg;

    sprite_blit_source #(
        .SOURCE_ID(SRC), .SOURCE_SEL_ADDRW(2), .DRAW_WIDTH(DW), .DRAW_HEIGHT(DH),
        .SPRITE_W(SW), .SPRITE_H(SH), .COLOR_DEPTH(9), .TRANSPARENT_COLOR(TC)
    ) dut (
        .clk(clk), .reset(reset), .write_awaited(write_awaited),
        .write_source_sel(write_source_sel), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_visible(sprite_visible), .rom_addr(rom_addr), .rom_data(rom_data),
        .write_active(write_active), .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
        .write_color_data(write_color_data), .write_transparent(write_transparent),
        .draw_done(draw_done), .state_dbg(state_dbg)
    );

    logic [8:0] rom_mem [NPIX];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int color;
        int transp;
        bit chk_color;
        int at;
    } pix_t;

    pix_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wa_seen = 0;
    pix_t mp;

    function void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (write_active) begin
                wa_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    mp = exp_q.pop_front();
                    chk("px_cycle", cyc, mp.at);
                    chk("px_x", int'(write_x_addr), mp.x);
                    chk("px_y", int'(write_y_addr), mp.y);
                    chk("px_transp", int'(write_transparent), mp.transp);
                    if (mp.chk_color) chk("px_color", int'(write_color_data), mp.color);
                end
            end
            if (draw_done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // Reference model: the list of pixels a pass should produce, in raster order.
    task automatic expect_pass(input int lx, input int ly, input bit vis, input int t);
        pix_t p;
        if (vis) begin
            for (int r = 0; r < SH; r++) begin
                for (int c = 0; c < SW; c++) begin
                    p.x = (lx + c) % 1024;
                    p.y = (ly + r) % 512;
                    p.color = int'(rom_mem[r*SW + c]);
                    p.transp = ((rom_mem[r*SW + c] == TC) || (lx + c >= DW) || (ly + r >= DH)) ? 1 : 0;
                    p.chk_color = 1'b1;
                    p.at = t + 2 + r*SW + c;
                    exp_q.push_back(p);
                end
            end
            done_q.push_back(t + 2 + NPIX);
        end else begin
            p.x = 0; p.y = 0; p.color = 0; p.transp = 1; p.chk_color = 1'b0; p.at = t + 2;
            exp_q.push_back(p);
            done_q.push_back(t + 3);
        end
    endtask

    // rom_mode: 0 = 0..N-1, 1 = 0..N-1 with entry 5 transparent, 2 = random
    task automatic fill_rom(input int rom_mode);
        for (int i = 0; i < NPIX; i++) begin
            if (rom_mode == 2) rom_mem[i] = ($urandom_range(0, 99) < 20) ? TC : 9'($urandom_range(0, 510));
            else rom_mem[i] = 9'(i);
        end
        if (rom_mode == 1) rom_mem[5] = TC;
    endtask

    task automatic grant_start(input int lx, input int ly, input bit vis, output int t);
        sprite_x = 10'(lx);
        sprite_y = 9'(ly);
        sprite_visible = vis;
        write_source_sel = 2'(SRC);
        write_awaited = 1'b1;
        t = cyc + 1;
        expect_pass(lx, ly, vis, t);
        @(negedge clk);
        // Inputs after the latch cycle must be ignored.
        sprite_x = 10'($urandom);
        sprite_y = 9'($urandom);
        sprite_visible = ~vis;
        @(negedge clk);
        chk("rom_addr_start", int'(rom_addr), 0);
    endtask

    task automatic run_pass(input int lx, input int ly, input bit vis, input int hold, input int rom_mode);
        int t;
        int n;
        int wa0;
        fill_rom(rom_mode);
        wa0 = wa_seen;
        grant_start(lx, ly, vis, t);
        n = 0;
        while (!write_active && n < 50) begin @(negedge clk); n++; end
        if (!write_active) chk("wa_rise_timeout", 0, 1);
        n = 0;
        while (write_active && n < 50) begin @(negedge clk); n++; end
        if (write_active) chk("wa_fall_timeout", 1, 0);
        repeat (hold) @(negedge clk);
        write_awaited = 1'b0;
        repeat (3) @(negedge clk);
        chk("pass_len", wa_seen - wa0, vis ? NPIX : 1);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
    endtask

    initial begin
        int t;
        int wa0;
        fill_rom(0);
        repeat (2) @(negedge clk);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_write_active", int'(write_active), 0);
        chk("rst_x", int'(write_x_addr), 0);
        chk("rst_y", int'(write_y_addr), 0);
        chk("rst_transp", int'(write_transparent), 0);
        chk("rst_done", int'(draw_done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_pass(10, 20, 1'b1, 0, 0);
        run_pass(10, 20, 1'b1, 1, 1);
        run_pass(DW - 2, 20, 1'b1, 0, 0);
        run_pass(100, DH - 1, 1'b1, 2, 0);
        run_pass(1022, 511, 1'b1, 0, 0);
        run_pass(50, 60, 1'b0, 3, 0);
        run_pass(300, 200, 1'b1, 3, 2);

        // Grant for another source index must not start a pass.
        for (int s = 0; s < 4; s++) begin
            if (s != SRC) begin
                wa0 = wa_seen;
                write_source_sel = 2'(s);
                sprite_visible = 1'b1;
                write_awaited = 1'b1;
                repeat (10) @(negedge clk);
                write_awaited = 1'b0;
                @(negedge clk);
                chk("no_pass_wrong_sel", wa_seen - wa0, 0);
            end
        end

        // Reset in the middle of a pass.
        fill_rom(2);
        grant_start(200, 100, 1'b1, t);
        while (cyc < t + 4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_write_active", int'(write_active), 0);
        chk("midreset_rom_addr", int'(rom_addr), 0);
        chk("midreset_done", int'(draw_done), 0);
        exp_q.delete();
        done_q.delete();
        write_awaited = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_pass(200, 100, 1'b1, 0, 0);

        for (int i = 0; i < 25; i++) begin
            run_pass($urandom_range(0, 1023), $urandom_range(0, 511),
                     ($urandom_range(0, 4) != 0), $urandom_range(0, 4), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_blit_source.md
Name: sprite_blit_source

Overview:
- Write-side client of the double-buffered frame manager. Acts as one numbered write source and copies a SPRITE_W x SPRITE_H bitmap from a sync-read sprite ROM into the back framebuffer at (sprite_x, sprite_y).
- Answers the manager's write_awaited / write_source_sel grant, streams one pixel per clock on the pixel write bus, then drops write_active to hand the grant back.
- Clips pixels that fall off screen by marking them transparent.

Parameters:
SOURCE_ID, 0, index this instance answers to on write_source_sel
SOURCE_SEL_ADDRW, 1, width of write_source_sel
DRAW_WIDTH, 640, screen width in pixels
DRAW_HEIGHT, 480, screen height in pixels
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 32, sprite height in pixels
COLOR_DEPTH, 9, pixel color width
TRANSPARENT_COLOR, 9'h1FF, ROM value rendered as transparent

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
write_awaited  in  1  manager requests a write pass from the selected source
write_source_sel  in  SOURCE_SEL_ADDRW  currently selected source index
sprite_x  in  $clog2(DRAW_WIDTH)  sprite top-left x, sampled at grant
sprite_y  in  $clog2(DRAW_HEIGHT)  sprite top-left y, sampled at grant
sprite_visible  in  1  0 = draw nothing this frame, sampled at grant
rom_addr  out  $clog2(SPRITE_W*SPRITE_H)  sprite ROM address, row-major
rom_data  in  COLOR_DEPTH  ROM data, valid 1 cycle after rom_addr
write_active  out  1  pixel write strobe; high for the whole pass
write_x_addr  out  $clog2(DRAW_WIDTH)  pixel x
write_y_addr  out  $clog2(DRAW_HEIGHT)  pixel y
write_color_data  out  COLOR_DEPTH  pixel color (equals rom_data)
write_transparent  out  1  1 = manager must not store this pixel
draw_done  out  1  one-cycle pulse on the cycle write_active falls

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - rom_addr, write_active, write_x_addr, write_y_addr, write_transparent and draw_done are all 0.
  - A reset mid-pass drops write_active immediately.
- grant = write_awaited && (write_source_sel == SOURCE_ID).
- IDLE:
  - On grant, latch sprite_x, sprite_y and sprite_visible, clear col/row, then go to DRAW if visible, else STUB.
  - Latch cycle = T.
- DRAW:
  - Counters col (0..SPRITE_W-1) and row (0..SPRITE_H-1). col wraps to 0 and increments row; rom_addr = row*SPRITE_W+col (registered), first value at T+1.
  - Stage 2 registers: write_active=1, x = lx+col and y = ly+row, each computed at 1 bit wider than the screen coordinate. These are aligned with rom_data, so pixel (0,0) appears at T+2.
  - write_transparent = (rom_data == TRANSPARENT_COLOR) || wide x >= DRAW_WIDTH || wide y >= DRAW_HEIGHT.
  - write_x_addr / write_y_addr are the truncated low bits.
  - After the last address (row=H-1, col=W-1) is issued, go to DRAIN.
- DRAIN: the final pixel is emitted; the next cycle has write_active=0 and draw_done=1; go to RELEASE.
- Pass timing: write_active is high for exactly SPRITE_W*SPRITE_H contiguous cycles, T+2 .. T+1+W*H, and never has a gap.
- STUB (invisible sprite):
  - One write_active=1 cycle at T+2 with write_transparent=1, addresses 0.
  - Then write_active=0 and draw_done=1; go to RELEASE.
  - Required because the manager waits for write_active to rise and then fall.
- RELEASE:
  - Stay until grant==0, then go to IDLE.
  - write_awaited lags write_active by one or more cycles, so this state prevents a second pass from the stale grant.
- Sampling rules:
  - sprite_x, sprite_y and sprite_visible changes after T have no effect until the next grant.
  - grant arriving in any state other than IDLE is ignored.
- Clipping:
  - Sprites partially off the right or bottom edge emit every cycle; clipped pixels have write_transparent=1.
  - Coordinates never wrap onto visible pixels.

Test Plan:
- W=4,H=2, lx=10, ly=20, ROM=0..7, grant at T -> write_active T+2..T+9; pixels (10,20)..(13,20) then (10,21)..(13,21) with colors 0..7, transparent=0; draw_done at T+10.
- ROM[5]=TRANSPARENT_COLOR -> 6th write cycle has write_transparent=1, all others 0.
- lx=DRAW_WIDTH-2 (638), W=4 -> cols 2,3 of each row have write_transparent=1; no write_x_addr<4 with transparent=0.
- sprite_visible=0 at grant -> exactly one write_active cycle at T+2 with transparent=1; draw_done at T+3; returns to IDLE only after grant drops.
- write_awaited held high 3 cycles after the pass, or write_source_sel!=SOURCE_ID at grant -> no second pass, or no pass at all; write_active stays 0.
- reset asserted mid-DRAW -> write_active=0 in the same cycle; after release with a fresh grant, a full pass restarts at rom_addr 0.
